receive_ram_writer: RTL and testbench

Serial-to-RAM capture block: the receive-direction counterpart of the RAM-to-terminal transmit path. Samples the `rx` line with the shared 16x baud strobe, assembles 8N1 characters and writes them as 7-bit ASCII into an internal 21-entry RAM at incrementing addresses. Capture ends on carriage return or when the RAM is full. The stored message is exposed through a registered read port for the controller or for retransmission.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/receive_ram_writer_if.sv | 33 +++
 rtl/uart_rx_core.sv | 109 ++++++++++
 rtl/receive_ram_writer.sv | 121 ++++++++++++
 tb/tb_receive_ram_writer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Used by the receive-side RAM writer and by the transmit-side controller.
// Contents:
//   rx_state_t        receiver FSM state encoding
//   OVERSAMPLE        strobes per bit (16x baud)
//   MID_SAMPLE        tick index of the mid-bit sample in the start bit
//   LAST_TICK         final tick of a bit period
//   CR                carriage return, the default end-of-message character
//   DEFAULT_ADDR_BITS default message RAM address width
//   DEFAULT_DEPTH     default message RAM depth
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int         OVERSAMPLE        = 16;
    localparam logic [3:0] MID_SAMPLE        = 4'd7;
    localparam logic [3:0] LAST_TICK         = 4'(OVERSAMPLE - 1);
    localparam logic [7:0] CR                = 8'h0D;
    localparam int         DEFAULT_ADDR_BITS = 5;
    localparam int         DEFAULT_DEPTH     = 21;

endpackage

// File: rtl/receive_ram_writer_if.sv
// Controller-facing bus of the receive RAM writer: capture restart,
// registered read port and message status.
// Signals:
//   clear          restart message capture (one-cycle pulse)
//   rd_address     read address
//   rd_data        registered read data
//   message_ready  message complete (terminator seen or RAM full)
//   message_length number of stored characters
//   framing_error  sticky, a stop bit was sampled low
//   overflow       sticky, a character arrived while message_ready was set
// Modports: slave = the writer, master = the controller.
interface receive_ram_writer_if #(
    parameter int ADDR_BITS  = 5,
    parameter int DATA_WIDTH = 7
);
    logic                  clear;
    logic [ADDR_BITS-1:0]  rd_address;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  message_ready;
    logic [ADDR_BITS-1:0]  message_length;
    logic                  framing_error;
    logic                  overflow;

    modport slave (
        input  clear, rd_address,
        output rd_data, message_ready, message_length, framing_error, overflow
    );

    modport master (
        output clear, rd_address,
        input  rd_data, message_ready, message_length, framing_error, overflow
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver with 16x oversampling.
// Ports:
//   clock, reset        system clock, asynchronous active-low reset
//   en_16_x_baud        one-cycle strobe at 16x baud
//   rx                  asynchronous serial input, idle high
//   byte_valid          one-cycle pulse, byte_data holds a good character
//   byte_data[7:0]      received character, LSB first on the line
//   framing_error_pulse one-cycle pulse, stop bit sampled low
module uart_rx_core
    import uart_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en_16_x_baud,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_error_pulse
);

    logic [1:0] sync_q;
    logic       rxs;
    rx_state_t  state_q;
    logic [3:0] tick_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic       byte_valid_q;
    logic       ferr_pulse_q;

    assign rxs = sync_q[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // Synchronizer starts at line-idle so reset release is not a start bit.
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            ferr_pulse_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx};
            byte_valid_q <= 1'b0;
            ferr_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        tick_q  <= '0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (en_16_x_baud) begin
                        if (tick_q == MID_SAMPLE) begin
                            if (rxs) begin
                                state_q <= ST_IDLE;     // glitch, not a start bit
                            end else begin
                                state_q <= ST_DATA;
                                tick_q  <= '0;
                                bit_q   <= '0;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    // Tick counter wraps every bit, so sampling stays mid-bit.
                    if (en_16_x_baud) begin
                        tick_q <= tick_q + 1'b1;
                        if (tick_q == LAST_TICK) begin
                            shift_q <= {rxs, shift_q[7:1]};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == 3'd7) begin
                                state_q <= ST_STOP;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (en_16_x_baud) begin
                        tick_q <= tick_q + 1'b1;
                        if (tick_q == LAST_TICK) begin
                            if (rxs) begin
                                byte_valid_q <= 1'b1;
                                state_q      <= ST_IDLE;
                            end else begin
                                ferr_pulse_q <= 1'b1;
                                state_q      <= ST_BREAK;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign byte_valid          = byte_valid_q;
    assign byte_data           = shift_q;
    assign framing_error_pulse = ferr_pulse_q;

endmodule

// File: rtl/receive_ram_writer.sv
// Serial-to-RAM message capture. Received characters are stored as 7-bit
// ASCII at incrementing addresses until the terminator arrives or the RAM
// fills; the message is read back through a registered read port.
// Ports:
//   clock, reset  system clock, asynchronous active-low reset
//   en_16_x_baud  one-cycle strobe at 16x baud
//   rx            asynchronous serial input, idle high
//   bus           controller bus (clear, read port, status flags)
module receive_ram_writer
    import uart_pkg::*;
#(
    parameter int         DATA_WIDTH = 7,
    parameter int         ADDR_BITS  = DEFAULT_ADDR_BITS,
    parameter int         DEPTH      = DEFAULT_DEPTH,
    parameter logic [7:0] TERMINATOR = CR
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en_16_x_baud,
    input  logic                 rx,
    receive_ram_writer_if.slave  bus
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       framing_error_pulse;

    uart_rx_core u_core (
        .clock               (clock),
        .reset               (reset),
        .en_16_x_baud        (en_16_x_baud),
        .rx                  (rx),
        .byte_valid          (byte_valid),
        .byte_data           (byte_data),
        .framing_error_pulse (framing_error_pulse)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic                  ready_q, ready_d;
    logic                  ovf_q, ovf_d;
    logic                  ferr_q, ferr_d;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_in_range;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        ready_d  = ready_q;
        ovf_d    = ovf_q;
        ferr_d   = ferr_q;
        wr_en    = 1'b0;
        if (bus.clear) begin
            // Clear takes priority; a byte landing in the same cycle is lost.
            wr_ptr_d = '0;
            ready_d  = 1'b0;
            ovf_d    = 1'b0;
            ferr_d   = 1'b0;
        end else begin
            if (framing_error_pulse) begin
                ferr_d = 1'b1;
            end
            if (byte_valid) begin
                if (ready_q) begin
                    ovf_d = 1'b1;
                end else if (byte_data == TERMINATOR) begin
                    ready_d = 1'b1;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_d == ADDR_BITS'(DEPTH)) begin
                        ready_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            ready_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
        end
    end

    // Storage is not reset so it maps onto block RAM. wr_ptr_q < DEPTH
    // whenever wr_en is set because a full RAM raises message_ready.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= byte_data[DATA_WIDTH-1:0];
        end
    end

    // Extra bit keeps the bound correct when DEPTH == 2**ADDR_BITS.
    assign rd_in_range = ({1'b0, bus.rd_address} < (ADDR_BITS + 1)'(DEPTH));

    // Non-blocking read of the array gives old data on a same-address write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_in_range) begin
            rd_data_q <= mem[bus.rd_address];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign bus.rd_data        = rd_data_q;
    assign bus.message_ready  = ready_q;
    assign bus.message_length = wr_ptr_q;
    assign bus.framing_error  = ferr_q;
    assign bus.overflow       = ovf_q;

endmodule

// File: tb/tb_receive_ram_writer.sv
// Testbench for receive_ram_writer: drives 8N1 frames on rx with a fast
// 16x strobe and compares status and RAM contents against a message model.
module tb_receive_ram_writer;
    import uart_pkg::*;

    localparam int STROBE_DIV = 4;
    localparam int BIT_CYC    = 16 * STROBE_DIV;
    localparam int DEPTH      = 21;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b0;
    logic rx    = 1'b1;

    receive_ram_writer_if #(.ADDR_BITS(5), .DATA_WIDTH(7)) bus ();

    receive_ram_writer dut (
        .clock        (clock),
        .reset        (reset),
        .en_16_x_baud (en),
        .rx           (rx),
        .bus          (bus.slave)
    );

    always #5 clock = ~clock;

    int strobe_cnt = 0;
    always @(negedge clock) begin
        strobe_cnt = (strobe_cnt + 1) % STROBE_DIV;
        en = (strobe_cnt == 0);
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Message model: what the controller should see after each character.
    logic [6:0] m_mem [DEPTH];
    int         m_len   = 0;
    bit         m_ready = 1'b0;
    bit         m_ovf   = 1'b0;
    bit         m_ferr  = 1'b0;

    task automatic model_clear();
        m_len = 0; m_ready = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_ready) begin
            m_ovf = 1'b1;
        end else if (b == 8'h0D) begin
            m_ready = 1'b1;
        end else begin
            m_mem[m_len] = b[6:0];
            m_len++;
            if (m_len == DEPTH) m_ready = 1'b1;
        end
    endtask

    bit arm_clear = 1'b0;
    bit collided  = 1'b0;

    // Holds rx for cyc cycles; optionally fires clear onto the byte_valid pulse.
    task automatic drive_bit(input logic v, input int cyc);
        rx = v;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clock);
            if (bus.clear) begin
                bus.clear = 1'b0;
            end else if (arm_clear && dut.byte_valid) begin
                bus.clear = 1'b1;
                arm_clear = 1'b0;
                collided  = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CYC);
        drive_bit(stop, BIT_CYC);
    endtask

    task automatic send_char(input logic [7:0] b);
        send_frame(b, 1'b1);
        model_byte(b);
        drive_bit(1'b1, int'($urandom_range(0, 20)));
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".len"},   32'(bus.message_length), 32'(m_len));
        chk({tag, ".ready"}, 32'(bus.message_ready),  32'(m_ready));
        chk({tag, ".ovf"},   32'(bus.overflow),       32'(m_ovf));
        chk({tag, ".ferr"},  32'(bus.framing_error),  32'(m_ferr));
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [6:0] exp);
        @(negedge clock);
        bus.rd_address = 5'(addr);
        @(negedge clock);
        chk(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        bus.clear = 1'b1;
        @(negedge clock);
        bus.clear = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".rd_data"}, 32'(bus.rd_data),        32'h0);
        chk({tag, ".ready"},   32'(bus.message_ready),  32'h0);
        chk({tag, ".len"},     32'(bus.message_length), 32'h0);
        chk({tag, ".ferr"},    32'(bus.framing_error),  32'h0);
        chk({tag, ".ovf"},     32'(bus.overflow),       32'h0);
    endtask

    initial begin
        logic [7:0] b;
        bus.clear      = 1'b0;
        bus.rd_address = '0;

        // Reset state
        #2 reset = 1'b0;
        #1 check_reset_values("reset");
        repeat (4) @(negedge clock);
        reset = 1'b1;
        drive_bit(1'b1, BIT_CYC);

        // Basic message "HI\r"
        send_char(8'h48);
        send_char(8'h49);
        send_char(8'h0D);
        check_status("hi");
        read_chk("hi.ram0", 0, 7'h48);
        read_chk("hi.ram1", 1, 7'h49);
        read_chk("hi.oob",  25, 7'h00);

        // Fill to capacity with random non-terminator bytes
        pulse_clear();
        check_status("clr");
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h0D) b = 8'h41;
            send_char(b);
            check_status($sformatf("fill%0d", i));
        end
        send_char(8'h41);
        check_status("fill.extra");
        for (int i = 0; i < DEPTH; i++) read_chk($sformatf("fill.ram%0d", i), i, m_mem[i]);
        read_chk("fill.oob", DEPTH, 7'h00);

        // Framing error then a good byte
        pulse_clear();
        send_frame(8'h55, 1'b0);
        m_ferr = 1'b1;
        drive_bit(1'b1, BIT_CYC);
        send_char(8'h31);
        check_status("ferr");
        read_chk("ferr.ram0", 0, 7'h31);

        // False start: low for 4 strobes only
        drive_bit(1'b0, 4 * STROBE_DIV);
        drive_bit(1'b1, 2 * BIT_CYC);
        check_status("false");
        send_char(8'h32);
        read_chk("false.ram1", 1, 7'h32);

        // Clear colliding with byte_valid while a message is ready
        send_char(8'h0D);
        check_status("ready");
        arm_clear = 1'b1;
        collided  = 1'b0;
        send_frame(8'h58, 1'b1);
        drive_bit(1'b1, 4);
        arm_clear = 1'b0;
        chk("coll.hit", 32'(collided), 32'h1);
        model_clear();
        check_status("coll");
        send_char(8'h7A);
        check_status("coll.next");
        read_chk("coll.ram0", 0, 7'h7A);

        // Reset during data bit 3
        b = 8'h42;
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 3; i++) drive_bit(b[i], BIT_CYC);
        drive_bit(b[3], BIT_CYC / 2);
        reset = 1'b0;
        rx    = 1'b1;
        #1 check_reset_values("midrst");
        repeat (4) @(negedge clock);
        reset = 1'b1;
        model_clear();
        drive_bit(1'b1, BIT_CYC);
        send_char(8'h42);
        check_status("midrst.next");
        read_chk("midrst.ram0", 0, 7'h42);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
